// File: rtl/hdmi_pkg.sv
// Shared types and defaults for the HDMI data-island scheduler.
// Holds the FSM encoding, preamble ctl code and default island timing.
package hdmi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_LEAD_GB,
        S_PACKET,
        S_TRAIL_GB
    } state_t;

    localparam logic [3:0] CTL_PREAMBLE = 4'b0101;

    localparam int DEF_ISLAND_START = 656;
    localparam int DEF_MAX_PKTS     = 2;
    localparam int DEF_PKT_LEN      = 32;
    localparam int DEF_PRE_LEN      = 8;
    localparam int DEF_GB_LEN       = 2;

    function automatic logic [1:0] rr_next(input logic [2:0] g);
        logic [1:0] n;
        n = 2'd0;
        unique case (1'b1)
            g[0]:    n = 2'd1;
            g[1]:    n = 2'd2;
            g[2]:    n = 2'd0;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter; ptr names the highest-priority requester.
// Purely combinational, one-hot (or zero) grant.
module rr_arbiter3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        unique case (ptr)
            2'd1: gnt = req[1] ? 3'b010 :
                        req[2] ? 3'b100 :
                        req[0] ? 3'b001 : 3'b000;
            2'd2: gnt = req[2] ? 3'b100 :
                        req[0] ? 3'b001 :
                        req[1] ? 3'b010 : 3'b000;
            default: gnt = req[0] ? 3'b001 :
                           req[1] ? 3'b010 :
                           req[2] ? 3'b100 : 3'b000;
        endcase
    end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// HDMI data-island scheduler: preamble, guard bands, round-robin packets.
// Define HDMI_NULL_PACKET_EN to send a null packet when nobody requests.
module hdmi_island_scheduler
    import hdmi_pkg::*;
#(
    parameter int ISLAND_START = DEF_ISLAND_START,
    parameter int MAX_PKTS     = DEF_MAX_PKTS,
    parameter int PKT_LEN      = DEF_PKT_LEN,
    parameter int PRE_LEN      = DEF_PRE_LEN,
    parameter int GB_LEN       = DEF_GB_LEN
) (
    input  logic       pixel_clk,
    input  logic       n_rst,
    input  logic [9:0] sx,
    input  logic       active_video,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [4:0] pkt_idx,
    output logic       null_pkt,
    output logic [3:0] ctl,
    output logic       di_preamble,
    output logic       data_island_gb,
    output logic       di_active,
    output logic       overrun_err
);

`ifdef HDMI_NULL_PACKET_EN
    localparam bit NULL_EN = 1'b1;
`else
    localparam bit NULL_EN = 1'b0;
`endif

    localparam int CW = 8;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [3:0]      sent;
    logic [1:0]      ptr;
    logic [2:0]      served;
    logic [2:0]      pend;
    logic [2:0]      arb_req;
    logic [2:0]      arb_gnt;
    logic            start_ok;

    // Each requester is served at most once per island.
    assign arb_req  = req & ~served;
    assign start_ok = NULL_EN || (req != 3'b000);

    rr_arbiter3 u_arb (
        .req (arb_req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    always_ff @(posedge pixel_clk or negedge n_rst) begin
        if (!n_rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            sent           <= '0;
            ptr            <= '0;
            served         <= '0;
            pend           <= '0;
            gnt            <= '0;
            pkt_idx        <= '0;
            null_pkt       <= 1'b0;
            ctl            <= '0;
            di_preamble    <= 1'b0;
            data_island_gb <= 1'b0;
            di_active      <= 1'b0;
            overrun_err    <= 1'b0;
        end else if (state != S_IDLE && active_video) begin
            state          <= S_IDLE;
            cnt            <= '0;
            gnt            <= '0;
            pkt_idx        <= '0;
            null_pkt       <= 1'b0;
            ctl            <= '0;
            di_preamble    <= 1'b0;
            data_island_gb <= 1'b0;
            di_active      <= 1'b0;
            overrun_err    <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt    <= '0;
                    sent   <= '0;
                    served <= '0;
                    if (sx == 10'(ISLAND_START) && !active_video
                        && start_ok) begin
                        state       <= S_PREAMBLE;
                        ctl         <= CTL_PREAMBLE;
                        di_preamble <= 1'b1;
                        pend        <= arb_gnt;
                        served      <= arb_gnt;
                        if (arb_gnt != 3'b000)
                            ptr <= rr_next(arb_gnt);
                    end
                end
                S_PREAMBLE: begin
                    if (cnt == CW'(PRE_LEN - 1)) begin
                        state          <= S_LEAD_GB;
                        cnt            <= '0;
                        ctl            <= '0;
                        di_preamble    <= 1'b0;
                        data_island_gb <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LEAD_GB: begin
                    if (cnt == CW'(GB_LEN - 1)) begin
                        state          <= S_PACKET;
                        cnt            <= '0;
                        data_island_gb <= 1'b0;
                        di_active      <= 1'b1;
                        gnt            <= pend;
                        null_pkt       <= NULL_EN && (pend == 3'b000);
                        pkt_idx        <= '0;
                        sent           <= sent + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PACKET: begin
                    if (cnt == CW'(PKT_LEN - 1)) begin
                        if (!null_pkt && arb_gnt != 3'b000
                            && int'(sent) < MAX_PKTS) begin
                            gnt     <= arb_gnt;
                            served  <= served | arb_gnt;
                            ptr     <= rr_next(arb_gnt);
                            sent    <= sent + 1'b1;
                            cnt     <= '0;
                            pkt_idx <= '0;
                        end else begin
                            state          <= S_TRAIL_GB;
                            cnt            <= '0;
                            gnt            <= '0;
                            pkt_idx        <= '0;
                            null_pkt       <= 1'b0;
                            di_active      <= 1'b0;
                            data_island_gb <= 1'b1;
                        end
                    end else begin
                        cnt     <= cnt + 1'b1;
                        pkt_idx <= 5'(cnt + 1'b1);
                    end
                end
                S_TRAIL_GB: begin
                    if (cnt == CW'(GB_LEN - 1)) begin
                        state          <= S_IDLE;
                        cnt            <= '0;
                        data_island_gb <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/hdmi_island_scheduler.md
HDMI_ISLAND_SCHEDULER -- requirements
Module: hdmi_island_scheduler

Interface
REQ-001 SHALL have parameters: ISLAND_START=656 (sx at which an island may begin); MAX_PKTS=2 (packets per island); PKT_LEN=32 (cycles per packet); PRE_LEN=8 (preamble cycles); GB_LEN=2 (guard-band cycles).
REQ-002 SHALL have ports: pixel_clk in 1, pixel clock; n_rst in 1, reset; sx in 10, horizontal pixel count; active_video in 1, video period flag.
REQ-003 SHALL have ports: req in 3, packet requests; gnt out 3, one-hot grant; pkt_idx out 5, packet cycle index; null_pkt out 1, null-packet cycle.
REQ-004 SHALL have ports: ctl out 4, ctl_0..ctl_3 override; di_preamble out 1, island preamble; data_island_gb out 1, island guard band; di_active out 1, packet period; overrun_err out 1, sticky error.
REQ-005 SHALL use one clock, pixel_clk; reset n_rst is asynchronous and active-low.

Function
REQ-006 SHALL implement states IDLE, PREAMBLE, LEAD_GB, PACKET, TRAIL_GB; all outputs registered.
REQ-007 IDLE->PREAMBLE when sx==ISLAND_START, active_video=0 and req!=0; first preamble cycle is the next cycle.
REQ-008 PREAMBLE SHALL last PRE_LEN cycles with ctl=ctl_0..3 = 1,0,1,0 and di_preamble=1; ctl=0 in all other states.
REQ-009 LEAD_GB and TRAIL_GB SHALL each last GB_LEN cycles with data_island_gb=1.
REQ-010 PACKET SHALL last PKT_LEN cycles with di_active=1 and pkt_idx counting 0..PKT_LEN-1 (0 outside PACKET).
REQ-011 Arbitration SHALL be round-robin over req[2:0], sampled on the cycle entering PREAMBLE and the last cycle of each PACKET; pointer starts at 0 and moves to one past the granted index.
REQ-012 gnt SHALL be held constant for all PKT_LEN cycles of the granted packet; req changes during a grant are ignored.
REQ-013 At the end of PACKET: if req!=0 and packets sent <MAX_PKTS, enter PACKET again for the new winner with no guard band; otherwise TRAIL_GB then IDLE.
REQ-014 Requester whose req drops before being sampled SHALL receive no grant.
REQ-015 If active_video=1 in any state other than IDLE, SHALL go to IDLE next cycle, clear all outputs except overrun_err, and set overrun_err=1.
REQ-016 The packet counter SHALL clear in IDLE; the round-robin pointer SHALL persist across islands.
REQ-017 sx==ISLAND_START while not IDLE SHALL be ignored.

Reset
REQ-018 While n_rst=0: state IDLE; gnt, pkt_idx, ctl=0; null_pkt, di_preamble, data_island_gb, di_active, overrun_err=0; pointer=0.
REQ-019 Reset mid-island SHALL abort immediately; no island resumes after release until the next sx==ISLAND_START.

Configuration
REQ-020 Macro HDMI_NULL_PACKET_EN: when defined, an island SHALL also start at sx==ISLAND_START with req==0, sending one packet with gnt=0 and null_pkt=1; when undefined, no island without a request and null_pkt is tied 0.

Structure
REQ-021 State encoding, ctl preamble code and default lengths SHALL live in shared package hdmi_pkg.
REQ-022 Round-robin arbiter SHALL be a sub-module rr_arbiter3 (req, pointer in; one-hot grant out).

Verification
REQ-023 req=001 held, sx sweeps to 656 -> preamble cycles 657..664 with ctl=0101; GB 665..666; gnt=001 for 667..698, pkt_idx 0..31; GB 699..700; IDLE.
REQ-024 req=111 held -> island 1 grants 001 then 010 back-to-back; the next line's island grants 100 then 001; no GB between packets.
REQ-025 req=000 at 656 -> no island; with HDMI_NULL_PACKET_EN, 32 cycles null_pkt=1 with gnt=000.
REQ-026 active_video forced to 1 during PACKET -> next cycle IDLE, all outputs 0, overrun_err=1 until n_rst.
REQ-027 n_rst pulsed low during PREAMBLE -> outputs 0 asynchronously; no activity until next sx==656 with req.
